// File: rtl/instruction_cycle_control_if.sv
// instruction_cycle_control_if: bus between the instruction-cycle controller and its environment
//   timer_in        one-hot T-step from the sequence counter
//   ir_in           instruction register contents
//   start_in        level request to set the running flip-flop
//   fgi_in, fgo_in  input/output device flags
//   sc_clear_out    sequence counter clear (next T-step is T0)
//   phase_out       0 HALTED, 1 FETCH, 2 DECODE, 3 INDIRECT, 4 EXECUTE, 5 INTERRUPT
//   opcode_out      latched one-hot D0..D7
//   indirect_out    latched I bit
//   r_out, ien_out  interrupt-cycle and interrupt-enable flip-flops
//   running_out     S flip-flop
//   timer_error_out sticky timing error
interface instruction_cycle_control_if #(
    parameter int TIMER_WIDTH = 16
);
    logic [TIMER_WIDTH-1:0] timer_in;
    logic [15:0]            ir_in;
    logic                   start_in;
    logic                   fgi_in;
    logic                   fgo_in;
    logic                   sc_clear_out;
    logic [2:0]             phase_out;
    logic [7:0]             opcode_out;
    logic                   indirect_out;
    logic                   r_out;
    logic                   ien_out;
    logic                   running_out;
    logic                   timer_error_out;

    modport slave (
        input  timer_in, ir_in, start_in, fgi_in, fgo_in,
        output sc_clear_out, phase_out, opcode_out, indirect_out,
               r_out, ien_out, running_out, timer_error_out
    );

    modport master (
        output timer_in, ir_in, start_in, fgi_in, fgo_in,
        input  sc_clear_out, phase_out, opcode_out, indirect_out,
               r_out, ien_out, running_out, timer_error_out
    );
endinterface

// File: rtl/instruction_cycle_control.sv
// instruction_cycle_control: fetch/decode/indirect/execute/interrupt sequencing for the basic computer
//   clock    rising-edge clock shared with the sequence counter
//   reset_n  asynchronous active-low reset
//   bus      instruction_cycle_control_if.slave (timer/IR/start/flags in; clear, phase, opcode,
//            I, R, IEN, S and error out)
module instruction_cycle_control #(
    parameter int TIMER_WIDTH = 16,
    parameter int MAX_STEP    = 6
) (
    input logic                        clock,
    input logic                        reset_n,
    instruction_cycle_control_if.slave bus
);
    localparam int SW = $clog2(TIMER_WIDTH);

    localparam logic [2:0] HALTED    = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] INDIRECT  = 3'd3;
    localparam logic [2:0] EXECUTE   = 3'd4;
    localparam logic [2:0] INTERRUPT = 3'd5;

    logic          s, r, ien, indirect, err;
    logic [7:0]    opcode;
    logic [SW-1:0] step, last;
    logic          one_hot, step_ok, run, bad, int_cycle;
    logic          decode_edge, io_step, hlt, ion, iof, ack, r_set;
    logic          sc_clear;
    logic [2:0]    phase;
    logic          unused_ir;

    assign unused_ir = ^{bus.ir_in[11:8], bus.ir_in[5:1]};

    always_comb begin
        step = '0;
        for (int k = 0; k < TIMER_WIDTH; k++)
            if (bus.timer_in[k]) step = SW'(k);
    end

    assign one_hot   = (bus.timer_in != '0) && ((bus.timer_in & (bus.timer_in - TIMER_WIDTH'(1))) == '0);
    assign step_ok   = one_hot && (int'(step) <= MAX_STEP);
    assign run       = s && step_ok;
    assign bad       = s && !step_ok;
    // R only redirects T0..T2; from T3 on the instruction that was running when R rose still finishes
    assign int_cycle = r && (step <= 2);
    assign last      = (opcode[3] || opcode[4]) ? SW'(4) : opcode[6] ? SW'(6) : opcode[7] ? SW'(3) : SW'(5);

    assign decode_edge = run && !int_cycle && (step == 2);
    assign io_step     = run && !int_cycle && (step == 3) && opcode[7];
    assign hlt         = io_step && !indirect && bus.ir_in[0];
    assign ion         = io_step && indirect && bus.ir_in[7];
    assign iof         = io_step && indirect && bus.ir_in[6];
    assign ack         = run && int_cycle && (step == 2);
    // an edge that clears IEN or halts outranks a new interrupt request
    assign r_set       = run && !r && (step >= 3) && ien && (bus.fgi_in || bus.fgo_in) && !hlt && !iof;

    // an illegal T-step while running reports HALTED and clears the counter to resynchronise
    always_comb begin
        sc_clear = 1'b1;
        phase    = HALTED;
        if (run) begin
            if (int_cycle) begin
                phase    = INTERRUPT;
                sc_clear = (step == 2);
            end else if (step <= 2) begin
                phase    = (step == 2) ? DECODE : FETCH;
                sc_clear = 1'b0;
            end else begin
                phase    = (step == 3 && !opcode[7]) ? INDIRECT : EXECUTE;
                sc_clear = (step == last);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s        <= 1'b0;
            r        <= 1'b0;
            ien      <= 1'b0;
            indirect <= 1'b0;
            err      <= 1'b0;
            opcode   <= 8'h00;
        end else if (bad) begin
            err <= 1'b1;
            s   <= 1'b0;
            r   <= 1'b0;
        end else begin
            if (!s && bus.start_in && !err) s <= 1'b1;
            if (hlt) s <= 1'b0;
            if (ack) r <= 1'b0;
            else if (r_set) r <= 1'b1;
            if (iof || ack) ien <= 1'b0;
            else if (ion) ien <= 1'b1;
            if (decode_edge) begin
                opcode   <= 8'b1 << bus.ir_in[14:12];
                indirect <= bus.ir_in[15];
            end
        end
    end

    assign bus.sc_clear_out    = sc_clear;
    assign bus.phase_out       = phase;
    assign bus.opcode_out      = opcode;
    assign bus.indirect_out    = indirect;
    assign bus.r_out           = r;
    assign bus.ien_out         = ien;
    assign bus.running_out     = s;
    assign bus.timer_error_out = err;
endmodule

// File: tb/tb_instruction_cycle_control.sv
// tb_instruction_cycle_control: directed and randomized checks against a behavioural model
module tb_instruction_cycle_control;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    instruction_cycle_control_if bus();
    instruction_cycle_control dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    bit m_s, m_r, m_ien, m_i, m_err;
    logic [7:0] m_opc;
    int m_d;
    int sc;
    int exp_ph;
    bit directed;
    logic [15:0] bad_t;
    logic [15:0] ir_v;
    int last_step [8] = '{5, 5, 5, 4, 4, 5, 6, 3};
    logic [15:0] dq [$] = '{16'h2123, 16'hE010, 16'hF080, 16'h2123, 16'h7001};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s = 0; m_r = 0; m_ien = 0; m_i = 0; m_err = 0; m_opc = 8'h00; m_d = 0; sc = 0;
    endtask

    task automatic check_all(input int ph, input bit clr);
        check("phase", 16'(bus.phase_out), 16'(ph));
        check("sc_clear", 16'(bus.sc_clear_out), 16'(clr));
        check("running", 16'(bus.running_out), 16'(m_s));
        check("r", 16'(bus.r_out), 16'(m_r));
        check("ien", 16'(bus.ien_out), 16'(m_ien));
        check("opcode", 16'(bus.opcode_out), 16'(m_opc));
        check("indirect", 16'(bus.indirect_out), 16'(m_i));
        check("error", 16'(bus.timer_error_out), 16'(m_err));
    endtask

    task automatic cycle();
        logic [15:0] tv;
        bit bad, clr, icyc, io, hlt, ion, iof, ack, rset, st, fi, fo;
        int t, ph;
        @(negedge clock);
        if (m_s && sc == 0 && !m_r)
            ir_v = (dq.size() > 0) ? dq.pop_front() : 16'($urandom);
        st = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        fi = directed ? 1'b1 : ($urandom_range(0, 7) == 0);
        fo = directed ? 1'b0 : ($urandom_range(0, 7) == 0);
        tv = (bad_t != 0) ? bad_t : (16'd1 << sc);
        bus.timer_in = tv; bus.ir_in = ir_v; bus.start_in = st; bus.fgi_in = fi; bus.fgo_in = fo;
        #1;
        bad = ($countones(tv) != 1) || (tv > 16'h0040);
        t = bad ? 0 : $clog2(tv);
        if (!m_s || bad) begin ph = 0; clr = 1; end
        else if (m_r && t <= 2) begin ph = 5; clr = (t == 2); end
        else if (t <= 2) begin ph = (t == 2) ? 2 : 1; clr = 0; end
        else begin ph = (t == 3 && m_d != 7) ? 3 : 4; clr = (t == last_step[m_d]); end
        exp_ph = ph;
        check_all(ph, clr);
        if (!m_s) begin
            if (st && !m_err) m_s = 1;
        end else if (bad) begin
            m_err = 1; m_s = 0; m_r = 0;
        end else begin
            icyc = m_r && t <= 2;
            io   = !icyc && t == 3 && m_d == 7;
            hlt  = io && !m_i && ir_v[0];
            ion  = io && m_i && ir_v[7];
            iof  = io && m_i && ir_v[6];
            ack  = icyc && t == 2;
            rset = !m_r && t >= 3 && m_ien && (fi || fo) && !hlt && !iof;
            if (!icyc && t == 2) begin
                m_d = int'(ir_v[14:12]); m_i = ir_v[15]; m_opc = 8'd1 << m_d;
            end
            if (hlt) m_s = 0;
            if (ack) m_r = 0; else if (rset) m_r = 1;
            if (iof || ack) m_ien = 0; else if (ion) m_ien = 1;
        end
        sc = clr ? 0 : sc + 1;
    endtask

    task automatic do_reset();
        bus.start_in = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(0, 1);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_to(input int step_no);
        int k;
        for (k = 0; k < 300 && !(m_s && sc == step_no); k++) cycle();
        if (k == 300) check("reach_step", 16'(sc), 16'(step_no));
    endtask

    initial begin
        int k;
        bad_t = 0; ir_v = 16'h0000; directed = 1;
        bus.timer_in = 16'h0001; bus.ir_in = 0; bus.start_in = 0; bus.fgi_in = 0; bus.fgo_in = 0;
        model_reset();
        repeat (2) @(negedge clock);
        #1 check_all(0, 1);
        reset_n = 1'b1;
        repeat (60) cycle();
        directed = 0;
        repeat (1500) cycle();
        for (k = 0; k < 500 && exp_ph != 4; k++) cycle();
        if (k == 500) check("reach_execute", 16'(exp_ph), 16'd4);
        #2 do_reset();
        run_to(3);
        bad_t = 16'h0080;
        cycle();
        bad_t = 0;
        repeat (12) cycle();
        do_reset();
        run_to(2);
        bad_t = 16'h0003;
        cycle();
        bad_t = 0;
        repeat (12) cycle();
        do_reset();
        repeat (200) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
